tick_stream_producer: RTL and testbench
=======================================

Name: tick_stream_producer

Overview:
- Producer end of the tick-driven counter path: converts clock_enable strobes into a valid/ready data stream.
- Its output stream is the one the consumer side reads.
- A switch-edge start/stop control gates the stream; a small FIFO absorbs consumer back-pressure.
- Sits between clock_enable and any stream consumer in the top level.

Parameters:
- WIDTH, 8, bit width of the sequence counter and o_data.
- DEPTH, 4, FIFO entries; power of two, minimum 2.

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- sw  input  1  level switch, already synchronous to clk; each rising edge toggles run/stop.
- i_en  input  1  one-cycle enable strobe from clock_enable.
- o_valid  output  1  FIFO head is valid.
- i_ready  input  1  consumer accepts the head this cycle.
- o_data  output  WIDTH  FIFO head value.
- o_running  output  1  high in the RUN state.
- o_drop_cnt  output  8  saturating count of strobes lost to a full FIFO.

Behaviour:
- Reset (rst_n low at a clk edge):
  - state=IDLE, FIFO empty, seq=0, sw_q=0, o_drop_cnt=0.
  - o_valid=0, o_running=0, o_data=0.
  - Reset mid-transfer discards all FIFO contents; no partial state survives.
- Edge detect: sw_q registers sw; sw_rise = sw & ~sw_q. The switch held high produces a single event.
- States:
  - IDLE: i_en ignored, seq held. sw_rise -> RUN.
  - RUN: each i_en pushes seq into the FIFO, then seq <= seq+1 modulo 2^WIDTH (wraps from all-ones to 0). sw_rise -> DRAIN.
  - DRAIN: no pushes, seq held. When the FIFO is empty -> IDLE.
  - sw_rise in DRAIN is ignored.
- o_running=1 only in RUN.
- Push/output timing:
  - Push at edge n with an empty FIFO -> o_valid=1 and o_data=pushed value after edge n (one cycle latency).
  - Head storage is registered; there is no combinational path from i_en to o_data.
- Handshake:
  - Pop occurs when o_valid & i_ready at an edge.
  - While o_valid=1 and i_ready=0, o_data and o_valid are held stable.
  - o_valid never depends on i_ready.
  - When the FIFO is empty, o_data holds its last value and o_valid=0.
- Full FIFO:
  - i_en in RUN with the FIFO full and no pop that cycle -> value dropped, o_drop_cnt+1 saturating at 255, seq still increments.
  - Full FIFO with a simultaneous pop -> push accepted, occupancy unchanged, no drop.
- Empty FIFO: a simultaneous push and pop cannot occur, because o_valid=0 on that cycle.
- i_en coincident with sw_rise in RUN: the push happens, then the state moves to DRAIN.
- i_en coincident with sw_rise in IDLE: no push; the state moves to RUN.
- Ordering: values leave in strictly increasing seq order modulo wrap, with gaps only where drops occurred.

Optional Feature:
- Macro: TICK_STREAM_PRODUCER_PARITY_EN.
- Defined:
  - Adds output o_parity (1 bit) = even parity (XOR reduction) of the stored entry.
  - Parity is computed at push and stored in the FIFO alongside the data (WIDTH+1 bits per entry).
  - o_parity is 0 at reset and is stable under the same rules as o_data.
- Undefined: port and storage bit absent; all other behaviour identical.

Decomposition:
- Package tick_stream_pkg:
  - typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t.
  - localparam DROP_MAX = 8'hFF.
  - Function even_parity.
- Sub-module tick_fifo:
  - Synchronous FIFO parameterised by WIDTH and DEPTH, synchronous active-low reset.
  - Ports: push/pop/din/dout/full/empty.
- The state machine, edge detect, seq counter and drop counter stay in tick_stream_producer.

Test Plan:
- Reset and start: hold rst_n=0 for 3 cycles, then release; pulse sw high for 5 cycles; i_en every 10 cycles; i_ready=1 -> single RUN entry; o_data sequence 0,1,2,3; each o_valid pulse 1 cycle, 1 cycle after its i_en; o_drop_cnt=0.
- Back-pressure: RUN, i_ready=0, 6 i_en strobes -> FIFO holds 0..3; o_drop_cnt=2; o_data=0 stable throughout; raising i_ready yields 0,1,2,3, then o_valid=0.
- Full with simultaneous pop: FIFO full, i_en and i_ready same cycle -> no drop; occupancy stays 4; next entries in order with no gap.
- Stop and drain: RUN with 3 entries queued; sw_rise -> o_running=0 next cycle; further i_en ignored; all 3 entries delivered; state returns to IDLE; a second sw_rise restarts at the held seq value.
- Wrap and saturation: WIDTH=4, 18 consumed strobes -> o_data ...,14,15,0,1; separately, 300 drops -> o_drop_cnt=255.
- Reset mid-operation: rst_n=0 with 2 entries queued -> o_valid=0, state IDLE, seq=0 the following cycle.
- Parity (macro defined): pushing 8'h07 gives o_parity=1 with o_data=8'h07; pushing 8'h03 gives o_parity=0.

Source files
------------

// File: rtl/tick_stream_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package    : tick_stream_pkg                                               |
// | Description: Shared types, constants and helpers for tick_stream_producer. |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
package tick_stream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [7:0] DROP_MAX = 8'hFF;

    // Callers zero-extend their operand; zero bits do not change the XOR.
    function automatic logic even_parity(input logic [31:0] value);
        return ^value;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tick_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : tick_fifo                                                     |
// | Description: Synchronous FIFO whose head output holds the last popped      |
// |              value while empty.                                            |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tick_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [c_AW-1:0]  wr_ptr_q;
    logic [c_AW-1:0]  rd_ptr_q;
    logic [c_AW:0]    cnt_q;
    logic [WIDTH-1:0] last_q;

    logic w_do_push;
    logic w_do_pop;

    assign empty_o   = (cnt_q == '0);
    assign full_o    = (cnt_q == (c_AW+1)'(DEPTH));
    assign w_do_pop  = pop_i & ~empty_o;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_do_push = push_i & (~full_o | w_do_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            last_q   <= '0;
        end else begin
            if (w_do_push) begin
                wr_ptr_q <= wr_ptr_q + c_AW'(1);
            end
            if (w_do_pop) begin
                rd_ptr_q <= rd_ptr_q + c_AW'(1);
                last_q   <= mem_q[rd_ptr_q];
            end
            case ({w_do_push, w_do_pop})
                2'b10:   cnt_q <= cnt_q + (c_AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (c_AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage needs no reset: an empty FIFO never exposes it.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    assign dout_o = empty_o ? last_q : mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: rtl/tick_stream_producer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : tick_stream_producer                                          |
// | Description: Turns clock-enable strobes into a valid/ready sequence stream |
// |              gated by a switch-edge run/stop control. Optional parity     |
// |              output enabled by TICK_STREAM_PRODUCER_PARITY_EN.             |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tick_stream_producer
    import tick_stream_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sw,
    input  logic             i_en,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_running,
    output logic [7:0]       o_drop_cnt
`ifdef TICK_STREAM_PRODUCER_PARITY_EN
    ,
    output logic             o_parity
`endif
);

`ifdef TICK_STREAM_PRODUCER_PARITY_EN
    localparam int c_FIFO_W = WIDTH + 1;
`else
    localparam int c_FIFO_W = WIDTH;
`endif

    state_t            state_q, state_d;
    logic              sw_q;
    logic [WIDTH-1:0]  seq_q, seq_d;
    logic [7:0]        drop_q, drop_d;

    logic              w_sw_rise;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic              w_drop;
    logic [c_FIFO_W-1:0] w_din;
    logic [c_FIFO_W-1:0] w_dout;

    assign w_sw_rise = sw & ~sw_q;
    assign w_push    = (state_q == RUN) & i_en;
    assign w_pop     = o_valid & i_ready;
    assign w_drop    = w_push & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sw_q    <= 1'b0;
            seq_q   <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            sw_q    <= sw;
            seq_q   <= seq_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        seq_d   = seq_q;
        drop_d  = drop_q;
        case (state_q)
            IDLE:    if (w_sw_rise) state_d = RUN;
            RUN:     if (w_sw_rise) state_d = DRAIN;
            DRAIN:   if (w_empty)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // The sequence advances on every accepted strobe, dropped or not.
        if (w_push) begin
            seq_d = seq_q + WIDTH'(1);
        end
        if (w_drop && (drop_q != DROP_MAX)) begin
            drop_d = drop_q + 8'd1;
        end
    end

`ifdef TICK_STREAM_PRODUCER_PARITY_EN
    assign w_din    = {even_parity(32'(seq_q)), seq_q};
    assign o_parity = w_dout[WIDTH];
`else
    assign w_din    = seq_q;
`endif

    tick_fifo #(
        .WIDTH (c_FIFO_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .din_i   (w_din),
        .dout_o  (w_dout),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    assign o_valid    = ~w_empty;
    assign o_data     = w_dout[WIDTH-1:0];
    assign o_running  = (state_q == RUN);
    assign o_drop_cnt = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_tick_stream_producer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : tb_tick_stream_producer                                       |
// | Description: Randomised bench for tick_stream_producer against a queue    |
// |              based reference model.                                        |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_tick_stream_producer;

    localparam int W = 8;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         sw = 1'b0;
    logic         i_en = 1'b0;
    logic         i_ready = 1'b0;
    logic         o_valid;
    logic [W-1:0] o_data;
    logic         o_running;
    logic [7:0]   o_drop_cnt;
`ifdef TICK_STREAM_PRODUCER_PARITY_EN
    logic         o_parity;
`endif

    always #5 clk = ~clk;

    tick_stream_producer #(.WIDTH(W), .DEPTH(D)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sw         (sw),
        .i_en       (i_en),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_data     (o_data),
        .o_running  (o_running),
        .o_drop_cnt (o_drop_cnt)
`ifdef TICK_STREAM_PRODUCER_PARITY_EN
        ,
        .o_parity   (o_parity)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: mode 0=idle, 1=run, 2=drain; q holds queued values.
    int m_mode = 0;
    int q[$];
    int m_last = 0;
    int m_seq  = 0;
    int m_drop = 0;
    bit m_swp  = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        int  sz0;
        bit  rise;
        if (!rst_n) begin
            m_mode = 0;
            q.delete();
            m_last = 0;
            m_seq  = 0;
            m_drop = 0;
            m_swp  = 1'b0;
        end else begin
            sz0  = q.size();
            rise = sw && !m_swp;
            if (sz0 > 0 && i_ready) m_last = q.pop_front();
            if (m_mode == 1 && i_en) begin
                if (q.size() < D) q.push_back(m_seq);
                else if (m_drop < 255) m_drop++;
                m_seq = (m_seq + 1) % (1 << W);
            end
            case (m_mode)
                0: if (rise) m_mode = 1;
                1: if (rise) m_mode = 2;
                default: if (sz0 == 0) m_mode = 0;
            endcase
            m_swp = sw;
        end
    endtask

    task automatic check_outputs();
        logic [W-1:0] exp_data;
        exp_data = (q.size() > 0) ? W'(q[0]) : W'(m_last);
        check_val("valid",   {31'd0, o_valid},   {31'd0, q.size() > 0});
        check_val("data",    {24'd0, o_data},    {24'd0, exp_data});
        check_val("running", {31'd0, o_running}, {31'd0, m_mode == 1});
        check_val("drop",    {24'd0, o_drop_cnt}, 32'(m_drop));
`ifdef TICK_STREAM_PRODUCER_PARITY_EN
        check_val("parity",  {31'd0, o_parity},  {31'd0, ^exp_data});
`endif
    endtask

    task automatic step(input bit r, input bit s, input bit e, input bit rd);
        rst_n   = r;
        sw      = s;
        i_en    = e;
        i_ready = rd;
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        bit swl;
        int rdy_pct;
        @(negedge clk);
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1);

        // Start with a long switch pulse, strobes every 10 cycles.
        for (int i = 0; i < 50; i++) step(1'b1, i < 5, (i % 10) == 9, 1'b1);

        // Back-pressure: six strobes into a stalled consumer, then release.
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, i % 2 == 1, 1'b0);
        for (int i = 0; i < 8; i++)  step(1'b1, 1'b0, 1'b0, 1'b1);

        // Full FIFO with simultaneous pop.
        for (int i = 0; i < 4; i++)  step(1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++)  step(1'b1, 1'b0, 1'b1, 1'b1);

        // Continuous throughput across the sequence wrap.
        for (int i = 0; i < 300; i++) step(1'b1, 1'b0, 1'b1, 1'b1);

        // Drop counter saturation.
        for (int i = 0; i < 300; i++) step(1'b1, 1'b0, 1'b1, 1'b0);

        // Stop with entries queued; strobes during drain must be ignored.
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b1, 1'b1);

        // Restart from the held sequence value, then reset mid-transfer.
        step(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1);

        // Randomised traffic with varying consumer readiness.
        swl     = 1'b0;
        rdy_pct = 50;
        for (int i = 0; i < 4000; i++) begin
            if (i % 200 == 0) rdy_pct = $urandom_range(0, 100);
            if ($urandom_range(0, 29) == 0) swl = ~swl;
            step($urandom_range(0, 599) != 0, swl,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(1, 100) <= rdy_pct);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
